// File: rtl/multiplier_pkg.sv
// Shared state encoding and sizing helpers for the sequential array multiplier.
package multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int calc_cycles(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Counter must be able to hold CYCLES itself, hence the +1.
    function automatic int cnt_width(input int width, input int bpc);
        return $clog2(width / bpc + 1);
    endfunction

endpackage

// File: rtl/pp_row.sv
// One partial-product row of the AND array: multiplicand gated by a single multiplier bit.
// Purely combinational, no handshake.
module pp_row #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] mag_a_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] row_o
);

    assign row_o = mag_a_i & {WIDTH{sel_i}};

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier: BPC partial-product rows per clock, WIDTH/BPC cycles per product.
// Accepts operands only in IDLE; holds the product in DONE until out_ready.
module seq_array_multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int BPC    = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CYCLES = calc_cycles(WIDTH, BPC);
    localparam int CW     = cnt_width(WIDTH, BPC);
    localparam int PW     = 2 * WIDTH;

    if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_params
        $error("seq_array_multiplier: WIDTH must be >= 2 and divisible by BPC");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mag_a_q, mag_a_d;
    logic [WIDTH-1:0]  mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     product_q, product_d;

    logic [WIDTH-1:0]  mag_a_in, mag_b_in;
    logic              neg_in;
    logic [WIDTH-1:0]  rows [BPC];
    logic [CW-1:0]     step_idx;
    logic [31:0]       shamt;
    logic [PW-1:0]     acc_sum;

    // The most negative value negates to itself, which read as unsigned is its magnitude.
    always_comb begin
        mag_a_in = a;
        mag_b_in = b;
        neg_in   = 1'b0;
        if (SIGNED) begin
            if (a[WIDTH-1]) mag_a_in = -a;
            if (b[WIDTH-1]) mag_b_in = -b;
            neg_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    for (genvar g = 0; g < BPC; g++) begin : g_row
        pp_row #(.WIDTH(WIDTH)) u_pp_row (
            .mag_a_i (mag_a_q),
            .sel_i   (mag_b_q[g]),
            .row_o   (rows[g])
        );
    end

    assign step_idx = CW'(CYCLES) - cnt_q;

    always_comb begin
        acc_sum = acc_q;
        shamt   = '0;
        for (int i = 0; i < BPC; i++) begin
            shamt   = 32'(step_idx) * 32'(BPC) + 32'(i);
            acc_sum = acc_sum + ({{WIDTH{1'b0}}, rows[i]} << shamt);
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mag_a_d = mag_a_in;
                    mag_b_d = mag_b_in;
                    neg_d   = neg_in;
                    acc_d   = '0;
                    cnt_d   = CW'(CYCLES);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d   = acc_sum;
                mag_b_d = mag_b_q >> BPC;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = (SIGNED && neg_q) ? -acc_sum : acc_sum;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for three multiplier configurations: 4x4 BPC=1 unsigned, BPC=2 unsigned, BPC=1 signed.
module tb_seq_array_multiplier;

    logic       clk;
    logic       rst;
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [3:0] a_s       [3];
    logic [3:0] b_s       [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [7:0] product   [3];
    logic       busy      [3];

    int tests;
    int fails;

    seq_array_multiplier #(.WIDTH(4), .BPC(1), .SIGNED(1'b0)) u_dut_u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .product(product[0]), .busy(busy[0]));

    seq_array_multiplier #(.WIDTH(4), .BPC(2), .SIGNED(1'b0)) u_dut_u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .product(product[1]), .busy(busy[1]));

    seq_array_multiplier #(.WIDTH(4), .BPC(1), .SIGNED(1'b1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_s[2]), .b(b_s[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .product(product[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         k;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand pair, wait (bounded) for the result, then complete the output handshake.
    task automatic do_op(input int k, input logic [3:0] av, input logic [3:0] bv,
                         output logic [7:0] p, output int lat, output bit err);
        err = 1'b0;
        @(negedge clk);
        if (!in_ready[k]) err = 1'b1;
        a_s[k] = av;
        b_s[k] = bv;
        in_valid[k] = 1'b1;
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 50) begin
            if (in_ready[k]) err = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
        p = product[k];
        @(negedge clk);
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1 out_ready[k] = 1'b0;
    endtask

    initial begin
        vec_t       vecs [12];
        logic [7:0] p;
        int         lat;
        bit         err;
        bit         ok;
        int         acc_edges [$];
        logic [7:0] prods [$];
        bit         acc_now;

        tests = 0;
        fails = 0;

        vecs[0]  = '{0, 4'd15, 4'd15, 8'hE1, 4};
        vecs[1]  = '{0, 4'd0,  4'd0,  8'h00, 4};
        vecs[2]  = '{0, 4'd10, 4'd3,  8'h1E, 4};
        vecs[3]  = '{1, 4'd9,  4'd6,  8'h36, 2};
        vecs[4]  = '{1, 4'd15, 4'd15, 8'hE1, 2};
        vecs[5]  = '{2, 4'h8,  4'h8,  8'h40, 4};
        vecs[6]  = '{2, 4'h8,  4'h7,  8'hC8, 4};
        vecs[7]  = '{2, 4'h0,  4'hF,  8'h00, 4};
        vecs[8]  = '{2, 4'hF,  4'hF,  8'h01, 4};
        vecs[9]  = '{2, 4'h7,  4'hF,  8'hF9, 4};
        vecs[10] = '{2, 4'h8,  4'h1,  8'hF8, 4};
        vecs[11] = '{2, 4'h9,  4'h3,  8'hEB, 4};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            a_s[k]       = '0;
            b_s[k]       = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_in_ready%0d", k),  32'(in_ready[k]),  32'd1);
            chk($sformatf("reset_out_valid%0d", k), 32'(out_valid[k]), 32'd0);
            chk($sformatf("reset_busy%0d", k),      32'(busy[k]),      32'd0);
            chk($sformatf("reset_product%0d", k),   32'(product[k]),   32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            do_op(vecs[v].k, vecs[v].a, vecs[v].b, p, lat, err);
            chk($sformatf("vec%0d_product", v), 32'(p), 32'(vecs[v].exp));
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            chk($sformatf("vec%0d_in_ready", v), 32'(err), 32'd0);
        end

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                do_op(1, 4'(ai), 4'(bi), p, lat, err);
                chk($sformatf("sweep_%0d_%0d", ai, bi), 32'(p), 32'(ai * bi));
            end
        end

        // Backpressure, with in_valid held high through CALC and DONE.
        @(negedge clk);
        a_s[0] = 4'd5;
        b_s[0] = 4'd3;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 a_s[0] = 4'd1;
        b_s[0] = 4'd1;
        lat = 0;
        while (!out_valid[0] && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("bp_latency", 32'(lat), 32'd4);
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (product[0] !== 8'h0F || out_valid[0] !== 1'b1 || busy[0] !== 1'b1 || in_ready[0] !== 1'b0)
                ok = 1'b0;
        end
        chk("bp_hold_stable", 32'(ok), 32'd1);
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        chk("bp_in_ready_after", 32'(in_ready[0]), 32'd1);
        chk("bp_product_kept",   32'(product[0]),  32'h0F);
        do_op(0, 4'd2, 4'd6, p, lat, err);
        chk("bp_next_product", 32'(p), 32'h0C);

        // Reset during CALC discards the in-flight result.
        @(negedge clk);
        a_s[2] = 4'd3;
        b_s[2] = 4'd3;
        in_valid[2] = 1'b1;
        @(posedge clk);
        #1 in_valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready[2]),  32'd1);
        chk("rst_out_valid", 32'(out_valid[2]), 32'd0);
        chk("rst_busy",      32'(busy[2]),      32'd0);
        chk("rst_product",   32'(product[2]),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid[2] !== 1'b0) ok = 1'b0;
        end
        chk("rst_no_spurious_valid", 32'(ok), 32'd1);
        do_op(2, 4'd3, 4'hD, p, lat, err);
        chk("rst_recover_product", 32'(p), 32'hF7);

        // Back-to-back with out_ready tied high.
        @(negedge clk);
        a_s[0] = 4'd3;
        b_s[0] = 4'd4;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            acc_now = in_valid[0] && in_ready[0];
            if (out_valid[0]) prods.push_back(product[0]);
            @(posedge clk);
            if (acc_now) acc_edges.push_back(e);
            #1;
            if (acc_now && acc_edges.size() == 1) begin
                a_s[0] = 4'd7;
                b_s[0] = 4'd9;
            end else if (acc_now && acc_edges.size() == 2) begin
                in_valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        out_ready[0] = 1'b0;
        chk("b2b_accept_count", 32'(acc_edges.size()), 32'd2);
        chk("b2b_product_count", 32'(prods.size()), 32'd2);
        if (acc_edges.size() == 2)
            chk("b2b_interval", 32'(acc_edges[1] - acc_edges[0]), 32'd6);
        if (prods.size() == 2) begin
            chk("b2b_product0", 32'(prods[0]), 32'h0C);
            chk("b2b_product1", 32'(prods[1]), 32'h3F);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
